// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART byte transmitter: FSM encoding, frame size, lane helpers.
package uart_tx_pkg;

   localparam int unsigned FRAME_BITS = 10;
   localparam int unsigned LANES      = 4;
   localparam int unsigned LANE_W     = 8;
   localparam int unsigned WORD_W     = LANES * LANE_W;
   localparam int unsigned BIT_CNT_W  = 3;

   localparam logic [LANES-1:0] META_LANE_MASK = 4'b1110;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SELECT = 3'd1,
      START  = 3'd2,
      DATA   = 3'd3,
      STOP   = 3'd4
   } tx_state_e;

   typedef struct packed {
      logic       found;
      logic [1:0] idx;
   } lane_sel_t;

   // Lowest lane whose skip bit is clear; found=0 when every lane is skipped.
   function automatic lane_sel_t next_lane(input logic [LANES-1:0] mask);
      lane_sel_t s;
      s.found = 1'b1;
      s.idx   = 2'd0;
      if (!mask[0])      s.idx = 2'd0;
      else if (!mask[1]) s.idx = 2'd1;
      else if (!mask[2]) s.idx = 2'd2;
      else if (!mask[3]) s.idx = 2'd3;
      else               s.found = 1'b0;
      return s;
   endfunction

   function automatic logic [LANE_W-1:0] lane_byte(input logic [WORD_W-1:0] word,
                                                   input logic [1:0]        idx);
      logic [LANE_W-1:0] b;
      case (idx)
         2'd0:    b = word[7:0];
         2'd1:    b = word[15:8];
         2'd2:    b = word[23:16];
         default: b = word[31:24];
      endcase
      return b;
   endfunction

endpackage

// File: rtl/uart_byte_transmitter_baud.sv
// Baud counter: counts CLK_DIV clocks per serial bit and pulses bit_done on the last one.
module uart_baud_counter
   import uart_tx_pkg::*;
#(
   parameter int unsigned CLK_DIV   = 100,
   parameter int unsigned DIV_WIDTH = 7
) (
   input  logic clock,
   input  logic extReset_n,
   input  logic clear,
   input  logic enable,
   output logic bit_done
);

   localparam logic [DIV_WIDTH-1:0] LAST = DIV_WIDTH'(CLK_DIV - 1);

   logic [DIV_WIDTH-1:0] count;

   assign bit_done = enable && (count == LAST);

   always_ff @(posedge clock or negedge extReset_n) begin
      if (!extReset_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= bit_done ? '0 : count + DIV_WIDTH'(1);
      end
   end

endmodule

// File: rtl/uart_byte_transmitter.sv
// UART 8N1 transmitter for metadata bytes and lane-masked 32-bit sample words.
module uart_byte_transmitter
   import uart_tx_pkg::*;
#(
   parameter int unsigned CLK_DIV   = 100,
   parameter int unsigned DIV_WIDTH = 7
) (
   input  logic              clock,
   input  logic              extReset_n,
   input  logic              send,
   input  logic [WORD_W-1:0] wrdata,
   input  logic [LANES-1:0]  disabledGroups,
   input  logic              writeMeta,
   input  logic [LANE_W-1:0] meta_data,
   output logic              txd,
   output logic              busy,
   output logic              xmit_idle
);

   tx_state_e              state_q, state_d;
   logic [WORD_W-1:0]      word_q, word_d;
   logic [LANES-1:0]       mask_q, mask_d;
   logic [LANE_W-1:0]      shift_q, shift_d;
   logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
   logic                   txd_d;
   logic                   busy_d;
   logic                   bit_done;
   logic                   baud_clear;
   lane_sel_t              sel;

   // Counter sits at zero outside the timed states so every timed state starts a fresh bit.
   assign baud_clear = (state_q == IDLE) || (state_q == SELECT);
   assign sel        = next_lane(mask_q);
   assign xmit_idle  = (state_q == IDLE);

   uart_baud_counter #(
      .CLK_DIV   (CLK_DIV),
      .DIV_WIDTH (DIV_WIDTH)
   ) u_baud (
      .clock      (clock),
      .extReset_n (extReset_n),
      .clear      (baud_clear),
      .enable     (!baud_clear),
      .bit_done   (bit_done)
   );

   // Next-state, datapath and line value; lanes are retired by setting their skip bit.
   always_comb begin
      state_d   = state_q;
      word_d    = word_q;
      mask_d    = mask_q;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      txd_d     = txd_q_hold();

      unique case (state_q)
         IDLE: begin
            if (writeMeta) begin
               word_d  = {(WORD_W - LANE_W)'(0), meta_data};
               mask_d  = META_LANE_MASK;
               state_d = SELECT;
            end else if (send) begin
               word_d  = wrdata;
               mask_d  = disabledGroups;
               state_d = SELECT;
            end
         end
         SELECT: begin
            if (sel.found) begin
               shift_d         = lane_byte(word_q, sel.idx);
               mask_d[sel.idx] = 1'b1;
               state_d         = START;
               txd_d           = 1'b0;
            end else begin
               state_d = IDLE;
            end
         end
         START: begin
            if (bit_done) begin
               state_d   = DATA;
               bit_cnt_d = '0;
               txd_d     = shift_q[0];
            end
         end
         DATA: begin
            if (bit_done) begin
               if (bit_cnt_q == BIT_CNT_W'(7)) begin
                  state_d = STOP;
                  txd_d   = 1'b1;
               end else begin
                  bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                  shift_d   = {1'b0, shift_q[LANE_W-1:1]};
                  txd_d     = shift_q[1];
               end
            end
         end
         STOP: begin
            if (bit_done) begin
               if (sel.found) begin
                  shift_d         = lane_byte(word_q, sel.idx);
                  mask_d[sel.idx] = 1'b1;
                  state_d         = START;
                  txd_d           = 1'b0;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
            txd_d   = 1'b1;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   function automatic logic txd_q_hold();
      return txd;
   endfunction

   always_ff @(posedge clock or negedge extReset_n) begin
      if (!extReset_n) begin
         state_q   <= IDLE;
         word_q    <= '0;
         mask_q    <= '0;
         shift_q   <= '0;
         bit_cnt_q <= '0;
         txd       <= 1'b1;
         busy      <= 1'b0;
      end else begin
         state_q   <= state_d;
         word_q    <= word_d;
         mask_q    <= mask_d;
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
         txd       <= txd_d;
         busy      <= busy_d;
      end
   end

endmodule

// File: tb/tb_uart_byte_transmitter.sv
// Self-checking bench for uart_byte_transmitter: serial stream compared against a frame-level model.
module tb_uart_byte_transmitter;

   localparam int unsigned CLK_DIV   = 4;
   localparam int unsigned DIV_WIDTH = 2;
   localparam int          FRAME     = 10 * CLK_DIV;
   localparam int          LOG_MAX   = 256;

   logic        clock = 1'b0;
   logic        extReset_n = 1'b0;
   logic        send = 1'b0;
   logic [31:0] wrdata = '0;
   logic [3:0]  disabledGroups = '0;
   logic        writeMeta = 1'b0;
   logic [7:0]  meta_data = '0;
   logic        txd;
   logic        busy;
   logic        xmit_idle;

   int checks = 0;
   int errors = 0;

   logic txd_log  [LOG_MAX];
   logic busy_log [LOG_MAX];
   logic idle_log [LOG_MAX];

   bit         exp_q[$];
   logic [7:0] exp_bytes[$];
   logic [7:0] rx_bytes[$];

   uart_byte_transmitter #(
      .CLK_DIV   (CLK_DIV),
      .DIV_WIDTH (DIV_WIDTH)
   ) dut (
      .clock          (clock),
      .extReset_n     (extReset_n),
      .send           (send),
      .wrdata         (wrdata),
      .disabledGroups (disabledGroups),
      .writeMeta      (writeMeta),
      .meta_data      (meta_data),
      .txd            (txd),
      .busy           (busy),
      .xmit_idle      (xmit_idle)
   );

   always #5 clock = ~clock;

   // Reference: each enabled lane in ascending order becomes start, 8 data bits LSB first, stop.
   task automatic build_model(input logic [31:0] word, input logic [3:0] mask);
      exp_q.delete();
      exp_bytes.delete();
      for (int lane = 0; lane < 4; lane++) begin
         if (!mask[lane]) begin
            logic [7:0] b = word[8*lane +: 8];
            exp_bytes.push_back(b);
            for (int c = 0; c < CLK_DIV; c++) exp_q.push_back(1'b0);
            for (int i = 0; i < 8; i++)
               for (int c = 0; c < CLK_DIV; c++) exp_q.push_back(b[i]);
            for (int c = 0; c < CLK_DIV; c++) exp_q.push_back(1'b1);
         end
      end
   endtask

   // Cycle k is sampled just after edge E+k, E being the accepting edge.
   function automatic logic exp_txd(input int k);
      return (k >= 1 && k <= exp_q.size()) ? exp_q[k-1] : 1'b1;
   endfunction

   function automatic logic exp_busy(input int k);
      return (k <= exp_q.size());
   endfunction

   function automatic int find_wave_err(input int n);
      for (int k = 0; k < n; k++) begin
         if (txd_log[k] !== exp_txd(k) || busy_log[k] !== exp_busy(k) ||
             idle_log[k] !== !exp_busy(k))
            return k;
      end
      return -1;
   endfunction

   task automatic strobe(input logic do_send, input logic do_meta,
                         input logic [31:0] w, input logic [3:0] m, input logic [7:0] md);
      @(negedge clock);
      send           = do_send;
      writeMeta      = do_meta;
      wrdata         = w;
      disabledGroups = m;
      meta_data      = md;
      @(posedge clock);
      #1;
      send           = 1'b0;
      writeMeta      = 1'b0;
      wrdata         = $urandom;
      disabledGroups = 4'($urandom);
      meta_data      = 8'($urandom);
   endtask

   task automatic capture(input int n, input int inject_at);
      for (int k = 0; k < n; k++) begin
         if (k > 0) begin
            @(posedge clock);
            #1;
         end
         txd_log[k]  = txd;
         busy_log[k] = busy;
         idle_log[k] = xmit_idle;
         if (k == inject_at) begin
            writeMeta = 1'b1;
            meta_data = 8'($urandom);
         end else begin
            writeMeta = 1'b0;
         end
      end
   endtask

   // Host-side receiver: finds start bits and samples each bit mid-period.
   task automatic decode(input int n);
      int k = 0;
      rx_bytes.delete();
      while (k + FRAME <= n) begin
         if (txd_log[k] === 1'b0) begin
            logic [7:0] b;
            for (int i = 0; i < 8; i++) b[i] = txd_log[k + CLK_DIV/2 + CLK_DIV*(i+1)];
            if (txd_log[k + CLK_DIV/2 + CLK_DIV*9] !== 1'b1) b = 8'hxx;
            rx_bytes.push_back(b);
            k = k + FRAME - CLK_DIV;
         end else begin
            k++;
         end
      end
   endtask

   task automatic report_wave(input string name, input int bad);
      checks++;
      if (bad != -1) begin
         errors++;
         $display("FAIL %s: cycle %0d got txd=%b busy=%b idle=%b, expected txd=%b busy=%b idle=%b",
                  name, bad, txd_log[bad], busy_log[bad], idle_log[bad],
                  exp_txd(bad), exp_busy(bad), !exp_busy(bad));
      end
   endtask

   task automatic test_reset();
      extReset_n = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      checks++;
      if (txd !== 1'b1 || busy !== 1'b0 || xmit_idle !== 1'b1) begin
         errors++;
         $display("FAIL reset_values: got txd=%b busy=%b idle=%b, expected 1 0 1", txd, busy, xmit_idle);
      end
      @(negedge clock);
      extReset_n = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      checks++;
      if (txd !== 1'b1 || busy !== 1'b0 || xmit_idle !== 1'b1) begin
         errors++;
         $display("FAIL post_reset_idle: got txd=%b busy=%b idle=%b, expected 1 0 1", txd, busy, xmit_idle);
      end
   endtask

   task automatic test_meta_byte();
      logic [9:0] pat = 10'b1010011110;
      int bad_c = -1;
      build_model(32'h0000_004F, 4'b1110);
      strobe(1'b0, 1'b1, 32'hDEAD_BEEF, 4'b0000, 8'h4F);
      capture(50, -1);
      report_wave("meta_4f_wave", find_wave_err(50));
      for (int c = 0; c < FRAME; c++)
         if (bad_c == -1 && txd_log[1+c] !== pat[c/CLK_DIV]) bad_c = c;
      checks++;
      if (bad_c != -1) begin
         errors++;
         $display("FAIL meta_4f_pattern: bit cycle %0d got %b, expected %b", bad_c,
                  txd_log[1+bad_c], pat[bad_c/CLK_DIV]);
      end
      checks++;
      if (idle_log[0] !== 1'b0 || idle_log[40] !== 1'b0 || idle_log[41] !== 1'b1) begin
         errors++;
         $display("FAIL meta_idle_timing: got idle[0]=%b idle[40]=%b idle[41]=%b, expected 0 0 1",
                  idle_log[0], idle_log[40], idle_log[41]);
      end
   endtask

   task automatic test_word(input string name, input logic [31:0] w, input logic [3:0] m,
                            input int exp_busy_cycles);
      int nb = 0;
      build_model(w, m);
      strobe(1'b1, 1'b0, w, m, 8'($urandom));
      capture(4*FRAME + 10, -1);
      report_wave({name, "_wave"}, find_wave_err(4*FRAME + 10));
      for (int k = 0; k < 4*FRAME + 10; k++) if (busy_log[k] === 1'b1) nb++;
      checks++;
      if (nb != exp_busy_cycles) begin
         errors++;
         $display("FAIL %s_busy_len: got %0d cycles, expected %0d", name, nb, exp_busy_cycles);
      end
      decode(4*FRAME + 10);
      checks++;
      if (rx_bytes != exp_bytes) begin
         errors++;
         $display("FAIL %s_bytes: got %p, expected %p", name, rx_bytes, exp_bytes);
      end
   endtask

   task automatic test_all_masked();
      int ones = 0;
      test_word("all_masked", 32'hA5A5_A5A5, 4'b1111, 1);
      for (int k = 0; k < 20; k++) if (txd_log[k] === 1'b1) ones++;
      checks++;
      if (ones != 20) begin
         errors++;
         $display("FAIL all_masked_txd: got %0d high cycles of 20, expected 20", ones);
      end
   endtask

   task automatic test_random_words();
      for (int it = 0; it < 6; it++) begin
         logic [31:0] w = $urandom;
         logic [3:0]  m = 4'($urandom);
         int n = 0;
         for (int l = 0; l < 4; l++) if (!m[l]) n++;
         test_word("random_word", w, m, 1 + n*FRAME);
      end
   endtask

   task automatic test_collision();
      logic [7:0] md = 8'($urandom);
      build_model({24'd0, md}, 4'b1110);
      strobe(1'b1, 1'b1, 32'h1234_5678, 4'b0000, md);
      capture(60, -1);
      report_wave("collision_meta_only", find_wave_err(60));
      md = 8'($urandom);
      build_model({24'd0, md}, 4'b1110);
      strobe(1'b0, 1'b1, 32'h0, 4'b0000, md);
      capture(80, 15);
      report_wave("lockout_during_data", find_wave_err(80));
   endtask

   task automatic test_reset_mid_frame();
      build_model(32'h0000_0037, 4'b1110);
      strobe(1'b0, 1'b1, 32'h0, 4'b0000, 8'h37);
      capture(18, -1);
      report_wave("pre_reset_wave", find_wave_err(18));
      #2;
      extReset_n = 1'b0;
      #1;
      checks++;
      if (txd !== 1'b1 || busy !== 1'b0 || xmit_idle !== 1'b1) begin
         errors++;
         $display("FAIL async_reset_mid_frame: got txd=%b busy=%b idle=%b, expected 1 0 1",
                  txd, busy, xmit_idle);
      end
      @(negedge clock);
      extReset_n = 1'b1;
      repeat (2) @(posedge clock);
      build_model(32'h0000_00A5, 4'b1110);
      strobe(1'b0, 1'b1, 32'h0, 4'b0000, 8'hA5);
      capture(50, -1);
      report_wave("after_reset_a5", find_wave_err(50));
      decode(50);
      checks++;
      if (rx_bytes.size() != 1 || rx_bytes[0] !== 8'hA5) begin
         errors++;
         $display("FAIL after_reset_decode: got %p, expected '{a5}", rx_bytes);
      end
   endtask

   task automatic test_meta_stream();
      logic [7:0] sent[$];
      logic [7:0] got[$];
      for (int i = 0; i < 8; i++) begin
         logic [7:0] md = 8'($urandom);
         int wait_cnt = 0;
         while (xmit_idle !== 1'b1 && wait_cnt < 100) begin
            @(posedge clock);
            #1;
            wait_cnt++;
         end
         if (wait_cnt >= 100) begin
            checks++;
            errors++;
            $display("FAIL stream_idle_timeout: got busy after %0d cycles, expected idle", wait_cnt);
         end
         sent.push_back(md);
         strobe(1'b0, 1'b1, $urandom, 4'($urandom), md);
         capture(FRAME + 2, -1);
         decode(FRAME + 2);
         foreach (rx_bytes[j]) got.push_back(rx_bytes[j]);
      end
      checks++;
      if (got != sent) begin
         errors++;
         $display("FAIL meta_stream_order: got %p, expected %p", got, sent);
      end
   endtask

   initial begin
      test_reset();
      test_meta_byte();
      test_word("full_word", 32'h1234_5678, 4'b0000, 161);
      test_word("masked_word", 32'h1234_5678, 4'b0101, 81);
      test_all_masked();
      test_random_words();
      test_collision();
      test_reset_mid_frame();
      test_meta_stream();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
